// File: rtl/instr_issue_encoder_pkg.sv
// Op codes, instruction-format fields and the idle word shared by the issuer and the decoder FSM.
// Pure declarations; no logic.
package instr_issue_encoder_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_CMP  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_LSH  = 4'b0111;
    localparam logic [3:0] OP_RSH  = 4'b1000;
    localparam logic [3:0] OP_ARSH = 4'b1001;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [3:0] MAJ_RTYPE = 4'b0000;
    localparam logic [3:0] MAJ_SHIFT = 4'b1000;
    localparam logic [3:0] EXT_LSH   = 4'b0100;

    // Register-form ext field (bits 7:4)
    localparam logic [3:0] EXT_ADD = 4'b0101;
    localparam logic [3:0] EXT_SUB = 4'b1001;
    localparam logic [3:0] EXT_CMP = 4'b1011;
    localparam logic [3:0] EXT_AND = 4'b0001;
    localparam logic [3:0] EXT_OR  = 4'b0010;
    localparam logic [3:0] EXT_XOR = 4'b0011;

    // Immediate-form major opcode (bits 15:12)
    localparam logic [3:0] OPC_ADDI = 4'b0101;
    localparam logic [3:0] OPC_SUBI = 4'b1001;
    localparam logic [3:0] OPC_CMPI = 4'b1011;
    localparam logic [3:0] OPC_ANDI = 4'b0001;
    localparam logic [3:0] OPC_ORI  = 4'b0010;
    localparam logic [3:0] OPC_XORI = 4'b0011;

    localparam logic [15:0] IDLE_WORD = 16'h40F0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic        legal;
        logic [15:0] word;
    } enc_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of encoded instruction words with show-ahead read data.
// Latency: push visible at head one edge later. Pushes while full and pops while empty are ignored.
module instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     push_vld,
    input  logic [15:0]              wr_dat,
    input  logic                     pop_rdy,
    output logic [15:0]              rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push_vld & ~full;
    assign pop_ok  = pop_rdy & ~empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue_encoder.sv
// Encodes field-level ALU commands into 16-bit words, queues them and issues each on Instr for a fixed hold window.
// Latency: command accepted at edge t into an empty queue while idle appears on Instr at edge t+1.
// Backpressure: In_ready is low while the queue is full; illegal commands handshake but are dropped.
module instr_issue_encoder
    import instr_issue_encoder_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ISSUE_CYCLES = 5,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     In_valid,
    output logic                     In_ready,
    input  logic [3:0]               Op_sel,
    input  logic                     Imm_sel,
    input  logic [3:0]               Rdest,
    input  logic [3:0]               Rsrc,
    input  logic [7:0]               Imm,
    output logic [15:0]              Instr,
    output logic                     Issue_strobe,
    output logic                     Illegal,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   Fifo_count
);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int MAXC = (ISSUE_CYCLES > GAP_CYCLES) ? ISSUE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    function automatic enc_t encode(input logic [3:0] op, input logic imm_sel,
                                    input logic [3:0] rdest, input logic [3:0] rsrc,
                                    input logic [7:0] imm);
        enc_t       e;
        logic [3:0] ext;
        logic [3:0] opc;
        logic       alu;
        e.legal = 1'b0;
        e.word  = IDLE_WORD;
        ext     = '0;
        opc     = '0;
        alu     = 1'b1;
        case (op)
            OP_ADD:  begin ext = EXT_ADD; opc = OPC_ADDI; end
            OP_SUB:  begin ext = EXT_SUB; opc = OPC_SUBI; end
            OP_CMP:  begin ext = EXT_CMP; opc = OPC_CMPI; end
            OP_AND:  begin ext = EXT_AND; opc = OPC_ANDI; end
            OP_OR:   begin ext = EXT_OR;  opc = OPC_ORI;  end
            OP_XOR:  begin ext = EXT_XOR; opc = OPC_XORI; end
            default: alu = 1'b0;
        endcase
        if (op == OP_LSH) begin
            // Shifts only exist in register form.
            e.legal = ~imm_sel;
            e.word  = {MAJ_SHIFT, rdest, EXT_LSH, rsrc};
        end else if (alu) begin
            e.legal = 1'b1;
            e.word  = imm_sel ? {opc, rdest, imm} : {MAJ_RTYPE, rdest, ext, rsrc};
        end
        return e;
    endfunction

    enc_t            cmd_enc;
    logic            in_acc;
    logic            push_vld;
    logic            pop_rdy;
    logic            fifo_full;
    logic            fifo_empty;
    logic [15:0]     head_dat;
    logic [CNTW-1:0] count_nxt;

    issue_state_t    state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [15:0]     instr_nxt;
    logic            strobe_nxt;

    assign cmd_enc   = encode(Op_sel, Imm_sel, Rdest, Rsrc, Imm);
    assign in_acc    = In_valid & In_ready;
    assign push_vld  = in_acc & cmd_enc.legal & ~fifo_full;
    assign count_nxt = Fifo_count + CNTW'(push_vld) - CNTW'(pop_rdy & ~fifo_empty);
    assign Busy      = ~fifo_empty | (state != ST_IDLE);

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .push_vld (push_vld),
        .wr_dat   (cmd_enc.word),
        .pop_rdy  (pop_rdy),
        .rd_dat   (head_dat),
        .count    (Fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Ready follows next-cycle occupancy so a full queue is never offered a slot.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            In_ready <= 1'b0;
            Illegal  <= 1'b0;
        end else begin
            In_ready <= (count_nxt != CNTW'(DEPTH));
            Illegal  <= in_acc & ~cmd_enc.legal;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            Instr        <= IDLE_WORD;
            Issue_strobe <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            Instr        <= instr_nxt;
            Issue_strobe <= strobe_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        instr_nxt  = Instr;
        strobe_nxt = 1'b0;
        pop_rdy    = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_nxt = IDLE_WORD;
                if (!fifo_empty) begin
                    pop_rdy    = 1'b1;
                    instr_nxt  = head_dat;
                    cnt_nxt    = CW'(ISSUE_CYCLES - 1);
                    strobe_nxt = 1'b1;
                    state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    instr_nxt = IDLE_WORD;
                    cnt_nxt   = CW'(GAP_CYCLES - 1);
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                instr_nxt = IDLE_WORD;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Bench for instr_issue_encoder: vector table, directed timing/reset sequences and random traffic
// checked every cycle against a timeline model of the issuer.
module tb_instr_issue_encoder;
    localparam int DEPTH  = 4;
    localparam int ISS    = 5;
    localparam int GAP    = 1;
    localparam int PERIOD = ISS + GAP + 1;
    localparam logic [15:0] IDLE_W = 16'h40F0;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [3:0]  Op_sel = '0;
    logic        Imm_sel = 1'b0;
    logic [3:0]  Rdest = '0;
    logic [3:0]  Rsrc = '0;
    logic [7:0]  Imm = '0;
    logic [15:0] Instr;
    logic        Issue_strobe;
    logic        Illegal;
    logic        Busy;
    logic [2:0]  Fifo_count;

    always #5 Clk = ~Clk;

    instr_issue_encoder #(.DEPTH(DEPTH), .ISSUE_CYCLES(ISS), .GAP_CYCLES(GAP)) dut (
        .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(In_ready),
        .Op_sel(Op_sel), .Imm_sel(Imm_sel), .Rdest(Rdest), .Rsrc(Rsrc), .Imm(Imm),
        .Instr(Instr), .Issue_strobe(Issue_strobe), .Illegal(Illegal), .Busy(Busy),
        .Fifo_count(Fifo_count)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference encoder: R/I-form ALU ops share a 4-bit code table, LSH is register-only.
    function automatic int ref_code(input logic [3:0] op);
        case (op)
            4'd0: return 'h5;
            4'd1: return 'h9;
            4'd2: return 'hB;
            4'd3: return 'h1;
            4'd4: return 'h2;
            4'd5: return 'h3;
            default: return -1;
        endcase
    endfunction

    function automatic bit ref_encode(input logic [3:0] op, input logic is, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [7:0] im, output logic [15:0] w);
        int c;
        c = ref_code(op);
        w = IDLE_W;
        if (op == 4'd7) begin
            w = {4'h8, rd, 4'h4, rs};
            return !is;
        end
        if (c < 0) return 0;
        w = is ? {c[3:0], rd, im} : {4'h0, rd, c[3:0], rs};
        return 1;
    endfunction

    // Timeline model: a word issued at edge m_issue is shown for ISS cycles; the issuer can
    // take the next word PERIOD edges later.
    logic [15:0] mq[$];
    logic [15:0] m_word = IDLE_W;
    int          cyc = 0;
    int          m_issue = -1000;
    bit          m_strobe, m_illegal, m_ready, last_acc;
    logic [15:0] dut_words[$];
    int          dut_cyc[$];

    task automatic model_reset();
        mq.delete();
        m_issue   = -1000;
        m_strobe  = 0;
        m_illegal = 0;
        m_ready   = 0;
    endtask

    task automatic model_edge();
        logic [15:0] w;
        bit legal, can_pop;
        cyc++;
        can_pop  = (cyc - m_issue >= PERIOD) && (mq.size() > 0);
        last_acc = (In_valid === 1'b1) && m_ready;
        legal    = ref_encode(Op_sel, Imm_sel, Rdest, Rsrc, Imm, w);
        m_illegal = last_acc && !legal;
        m_strobe  = can_pop;
        if (can_pop) begin
            m_word  = mq.pop_front();
            m_issue = cyc;
        end
        if (last_acc && legal) mq.push_back(w);
        m_ready = (mq.size() != DEPTH);
    endtask

    task automatic check_all();
        chk("instr", Instr, (cyc - m_issue < ISS) ? m_word : IDLE_W);
        chk("issue_strobe", Issue_strobe, m_strobe);
        chk("illegal", Illegal, m_illegal);
        chk("busy", Busy, (mq.size() != 0) || (cyc - m_issue < ISS + GAP));
        chk("in_ready", In_ready, m_ready);
        chk("fifo_count", Fifo_count, mq.size());
        if (Issue_strobe === 1'b1) begin
            dut_words.push_back(Instr);
            dut_cyc.push_back(cyc);
        end
    endtask

    task automatic cycle(input bit v, input logic [3:0] op, input bit is, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [7:0] im);
        In_valid = v; Op_sel = op; Imm_sel = is; Rdest = rd; Rsrc = rs; Imm = im;
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 4'h0, 0, 4'h0, 4'h0, 8'h00);
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_instr"}, Instr, IDLE_W);
        chk({tag, "_in_ready"}, In_ready, 1'b0);
        chk({tag, "_busy"}, Busy, 1'b0);
        chk({tag, "_count"}, Fifo_count, 3'd0);
        chk({tag, "_strobe"}, Issue_strobe, 1'b0);
        chk({tag, "_illegal"}, Illegal, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge Clk);
        #1 check_in_reset("rst_hold");
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0]  op;
        bit          is;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [7:0]  im;
        logic [15:0] exp_w;
        bit          exp_legal;
    } vec_t;

    vec_t tbl[14];
    logic [15:0] b2b_exp[4];

    initial begin
        tbl[0]  = '{4'h0, 0, 4'h3, 4'h5, 8'h00, 16'h0355, 1};  // ADD R3,R5
        tbl[1]  = '{4'h0, 1, 4'h2, 4'h0, 8'h7F, 16'h527F, 1};  // ADDI R2,#7F
        tbl[2]  = '{4'h2, 0, 4'h0, 4'h9, 8'h00, 16'h00B9, 1};  // CMP R0,R9
        tbl[3]  = '{4'h7, 0, 4'h1, 4'h4, 8'h00, 16'h8144, 1};  // LSH R1,R4
        tbl[4]  = '{4'h5, 1, 4'hF, 4'h0, 8'hFF, 16'h3FFF, 1};  // XORI R15,#FF
        tbl[5]  = '{4'h1, 0, 4'h6, 4'h7, 8'h00, 16'h0697, 1};  // SUB R6,R7
        tbl[6]  = '{4'h3, 1, 4'h4, 4'h0, 8'h3C, 16'h143C, 1};  // ANDI R4,#3C
        tbl[7]  = '{4'h4, 0, 4'h8, 4'h2, 8'h00, 16'h0822, 1};  // OR R8,R2
        tbl[8]  = '{4'h2, 1, 4'h7, 4'h0, 8'h80, 16'hB780, 1};  // CMPI R7,#80
        tbl[9]  = '{4'h6, 0, 4'h1, 4'h0, 8'h00, 16'h40F0, 0};  // NOT
        tbl[10] = '{4'h7, 1, 4'h1, 4'h0, 8'h05, 16'h40F0, 0};  // LSH immediate
        tbl[11] = '{4'hF, 0, 4'h2, 4'h3, 8'h00, 16'h40F0, 0};  // NOP
        tbl[12] = '{4'h9, 0, 4'h2, 4'h3, 8'h00, 16'h40F0, 0};  // ARSH
        tbl[13] = '{4'hC, 1, 4'h2, 4'h3, 8'h11, 16'h40F0, 0};  // undefined
        b2b_exp[0] = 16'h527F; b2b_exp[1] = 16'h00B9; b2b_exp[2] = 16'h8144; b2b_exp[3] = 16'h3FFF;

        // Power-on reset and quiet period
        #1 Rst = 1'b0;
        #1 check_in_reset("rst");
        release_reset();
        idle(4);

        // Vector table: single commands into an idle issuer
        foreach (tbl[i]) begin
            cycle(1, tbl[i].op, tbl[i].is, tbl[i].rd, tbl[i].rs, tbl[i].im);
            chk("tbl_illegal", Illegal, !tbl[i].exp_legal);
            cycle(0, 4'h0, 0, 4'h0, 4'h0, 8'h00);
            chk("tbl_word", Instr, tbl[i].exp_w);
            chk("tbl_strobe", Issue_strobe, tbl[i].exp_legal);
            idle(PERIOD + 1);
        end

        // Back-to-back issue timing
        dut_words.delete(); dut_cyc.delete();
        cycle(1, 4'h0, 1, 4'h2, 4'h0, 8'h7F);
        cycle(1, 4'h2, 0, 4'h0, 4'h9, 8'h00);
        cycle(1, 4'h7, 0, 4'h1, 4'h4, 8'h00);
        cycle(1, 4'h5, 1, 4'hF, 4'h0, 8'hFF);
        idle(4 * PERIOD + 2);
        chk("b2b_count", dut_words.size(), 4);
        for (int i = 0; i < dut_words.size() && i < 4; i++) chk("b2b_word", dut_words[i], b2b_exp[i]);
        for (int i = 1; i < dut_cyc.size(); i++) chk("b2b_period", dut_cyc[i] - dut_cyc[i-1], PERIOD);

        // Fill the queue while the issuer is busy
        begin
            logic [15:0] exp_q[$];
            logic [15:0] w;
            int acc = 0;
            bit saw_full = 0;
            dut_words.delete(); dut_cyc.delete();
            for (int k = 0; k < 60 && acc < 6; k++) begin
                cycle(1, 4'h0, 0, 4'(k), 4'(k + 1), 8'h00);
                if (last_acc) begin
                    void'(ref_encode(4'h0, 0, 4'(k), 4'(k + 1), 8'h00, w));
                    exp_q.push_back(w);
                    acc++;
                end
                if (Fifo_count == 3'd4) begin
                    saw_full = 1;
                    chk("full_ready_low", In_ready, 1'b0);
                end
            end
            chk("fill_accepted", acc, 6);
            chk("fill_saw_full", saw_full, 1);
            idle(7 * PERIOD);
            chk("fill_issued", dut_words.size(), exp_q.size());
            for (int i = 0; i < dut_words.size() && i < exp_q.size(); i++) chk("fill_order", dut_words[i], exp_q[i]);
        end

        // Reset in the third HOLD cycle with two words queued
        cycle(1, 4'h0, 0, 4'h3, 4'h5, 8'h00);
        cycle(1, 4'h1, 0, 4'h6, 4'h7, 8'h00);
        cycle(1, 4'h4, 0, 4'h8, 4'h2, 8'h00);
        cycle(0, 4'h0, 0, 4'h0, 4'h0, 8'h00);
        chk("pre_rst_instr", Instr, 16'h0355);
        chk("pre_rst_count", Fifo_count, 3'd2);
        #2 Rst = 1'b0;
        #1 check_in_reset("midhold_rst");
        In_valid = 1'b0;
        release_reset();
        idle(1);
        cycle(1, 4'h3, 1, 4'h4, 4'h0, 8'h3C);
        cycle(0, 4'h0, 0, 4'h0, 4'h0, 8'h00);
        chk("post_rst_word", Instr, 16'h143C);
        idle(3 * PERIOD);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            if (op == 4'd6) op = 4'd7;
            cycle($urandom_range(0, 2) != 0, op, $urandom_range(0, 1) == 1,
                  4'($urandom), 4'($urandom), 8'($urandom));
        end
        idle(DEPTH * PERIOD + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_issue_encoder.md
Name: instr_issue_encoder

Overview:
- Encoder/issuer that drives the 16-bit instruction word consumed by the register-file/ALU control FSM. It is the producing end of that Instr interface.
- Accepts field-level commands (ALU op, register/immediate select, Rdest, Rsrc, Imm8) over a valid/ready handshake and encodes them into instruction words at enqueue.
- Buffers encoded words in a small FIFO.
- Presents each word on Instr for a fixed hold window, then drives the idle word 16'h40F0 so the decoder parks in its fetch state between instructions.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- ISSUE_CYCLES, 5, Clk cycles each encoded word is held on Instr (>=1).
- GAP_CYCLES, 1, Clk cycles of idle word after each hold (>=1).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- In_valid  input  1  command valid.
- In_ready  output  1  command accepted when In_valid & In_ready.
- Op_sel  input  4  ALU op code: ADD 0000, SUB 0001, CMP 0010, AND 0011, OR 0100, XOR 0101, NOT 0110, LSH 0111, RSH 1000, ARSH 1001, NOP 1111.
- Imm_sel  input  1  1 = immediate form, 0 = register form.
- Rdest  input  4  destination register.
- Rsrc  input  4  source register (register form only).
- Imm  input  8  immediate (immediate form only).
- Instr  output  16  instruction word to the decoder.
- Issue_strobe  output  1  one-cycle pulse in the first cycle a new word appears on Instr.
- Illegal  output  1  one-cycle pulse, the cycle after an illegal command is accepted.
- Busy  output  1  high when FIFO is non-empty or state != IDLE.
- Fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Register-form encoding: {0000, Rdest, ext, Rsrc}.
  - ext: ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011.
- Shift encoding (LSH, register form only): {1000, Rdest, 0100, Rsrc}.
- Immediate-form encoding: {opc, Rdest, Imm}.
  - opc: ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011.
- Illegal commands: NOT, RSH, ARSH, NOP, undefined codes, and LSH with Imm_sel=1.
  - Handshake still completes.
  - Nothing is written to the FIFO.
  - Illegal pulses the next cycle.
- In_ready = (Fifo_count != DEPTH), registered from the count. No push into a full FIFO even if a pop happens the same edge.
- Push and pop on the same edge are allowed when not full. Fifo_count is unchanged in that case.
- Pointers wrap modulo DEPTH.
- Issue FSM states (cnt is a down-counter):
  - IDLE: Instr=16'h40F0.
    - If FIFO non-empty: pop, Instr<=word, cnt<=ISSUE_CYCLES-1, Issue_strobe<=1, go HOLD.
  - HOLD: Instr held.
    - If cnt==0: Instr<=16'h40F0, cnt<=GAP_CYCLES-1, go GAP.
    - Else: cnt--.
  - GAP: Instr=16'h40F0.
    - If cnt==0: go IDLE.
    - Else: cnt--.
- Latency: a command accepted at edge t into an empty FIFO while in IDLE appears on Instr at edge t+1.
- Steady-state issue period: ISSUE_CYCLES+GAP_CYCLES+1 cycles per word.
- Instr changes only on rising edges, so it is stable across the decoder's falling-edge sampling.
- Reset (Rst low, any time, including mid-HOLD):
  - FIFO emptied, state=IDLE, cnt=0.
  - Instr=16'h40F0.
  - Issue_strobe=0, Illegal=0, Busy=0, Fifo_count=0.
  - In_ready=0 while Rst is low; In_ready=1 from the first rising edge after release.
  - An in-flight word is discarded and not reissued.

Decomposition:
- Shared package holds:
  - ALU op-code constants (ADD..ARSH, NOP).
  - Instruction-format constants: R-type major 0000, shift major 1000, LSH ext 0100.
  - Per-op ext/opc constants.
  - IDLE_WORD = 16'h40F0.
- These constants are shared with the decoder FSM.
- One sub-module: instr_fifo (synchronous FIFO, DEPTH param, 16-bit data, count output).
- Encoding is a combinational function inside instr_issue_encoder.

Test Plan:
- Reset release, no input -> Instr=16'h40F0, Busy=0, In_ready=1, Issue_strobe never pulses.
- Push ADD R3,R5 (reg) -> Instr=16'h0355 one edge after accept, held 5 cycles, then 16'h40F0 for 1 cycle; Issue_strobe pulses once.
- Push ADDI R2,#7F, CMP R0,R9, LSH R1,R4, XORI R15,#FF back-to-back -> Instr sequence 16'h527F, 16'h00B9, 16'h8144, 16'h3FFF; each starts 7 cycles apart.
- Push 6 commands with the issuer busy -> In_ready drops when Fifo_count=4; order preserved; no word lost or duplicated.
- Push NOT R1, then LSH with Imm_sel=1 -> each handshakes, Illegal pulses once per command, Fifo_count stays 0, Instr stays 16'h40F0.
- Assert Rst in the 3rd HOLD cycle with 2 queued -> Instr=16'h40F0 immediately, Fifo_count=0; after release, a new push issues normally.
